cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
- Multi-cycle fetch/decode/execute/writeback sequencer that sits directly upstream of the 8-bit ALU.
- Fetches 16-bit instructions over a req/valid instruction-memory port and holds a 4x8 register file.
- Drives the ALU operands and opcode from registers, then captures the ALU result and flags in writeback.
- Also owns the PC, jumps, HALT and fetch-timeout fault handling.

Parameters:
- PC_W, 8, program counter / imem address width; PC wraps modulo 2^PC_W.
- RESET_PC, 0, PC value loaded on reset.
- FETCH_TIMEOUT, 16, max cycles FETCH waits for imem_valid before faulting (valid range 2..255).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request, high only in FETCH.
- imem_addr  out  PC_W  fetch address, equal to pc.
- imem_rdata  in  16  instruction word, sampled when imem_req and imem_valid are both high.
- imem_valid  in  1  instruction-memory response valid.
- alu_a  out  8  ALU operand A (registered).
- alu_b  out  8  ALU operand B (registered).
- alu_opcode  out  4  ALU opcode (registered).
- alu_result  in  8  ALU result, combinational from alu_a/alu_b/alu_opcode.
- alu_carry  in  1  ALU carry/borrow.
- alu_overflow  in  1  ALU overflow.
- pc  out  PC_W  current program counter.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry flag.
- flag_v  out  1  overflow flag.
- halted  out  1  high in HALT state.
- fault  out  1  sticky fetch-timeout fault.
- dbg_sel  in  2  register-file debug read select.
- dbg_data  out  8  combinational R[dbg_sel].

Behaviour:
- Reset (rst=1 at a clock edge; overrides any state, including mid-instruction):
  - state=FETCH; pc=RESET_PC.
  - R0..R3=0; ir=0; alu_a/alu_b/alu_opcode=0.
  - flags=0; halted=0; fault=0; timeout counter=0.
  - imem_req is low in the cycle following the reset edge only if rst is still high.
- Instruction format: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_valid: ir<=imem_rdata, counter cleared, go to DECODE.
  - Otherwise counter increments. When counter reaches FETCH_TIMEOUT-1 without valid, go to HALT with fault=1.
  - imem_valid outside FETCH is ignored.
- DECODE:
  - op 0000..1000 (ALU ops): alu_a<=R[rd]; alu_b<=imm if op=1000 (LDI), else R[rs]; alu_opcode<=op; go to EXECUTE.
  - op 1001 JMP: pc<=imm[PC_W-1:0]; go to FETCH.
  - op 1010 JZ: pc<=imm if flag_z, else pc+1; go to FETCH.
  - op 1111 HALT: go to HALT; pc unchanged.
  - op 1011..1110: NOP; pc<=pc+1; go to FETCH.
- EXECUTE: ALU inputs held stable for one full cycle; alu_result, alu_carry and alu_overflow are registered internally at end of cycle; go to WRITEBACK.
- WRITEBACK:
  - R[rd]<=captured result.
  - flag_z<=(result==8'h00) for all ALU ops, computed locally.
  - For op 0000/0001: flag_c<=carry, flag_v<=overflow. Other ALU ops clear flag_c and flag_v.
  - pc<=pc+1; go to FETCH.
- Latency:
  - ALU instruction: 4 cycles minimum (FETCH with immediate valid, DECODE, EXECUTE, WRITEBACK).
  - JMP/JZ/NOP: 2 cycles minimum.
  - Each extra imem wait cycle adds 1.
- PC wrap: pc+1 from 2^PC_W-1 gives 0. A jump target wider than PC_W is truncated.
- rd==rs is legal; both operands read the same register.
- HALT: absorbing; imem_req=0, halted=1, all state frozen, dbg_data still readable. Left only by reset.
- Flags are never modified by JMP, JZ, NOP or HALT.

Optional Feature:
- Macro CPU_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit) and a STEP_WAIT state.
  - After WRITEBACK, and after any DECODE that returns to FETCH, go to STEP_WAIT instead of FETCH.
  - STEP_WAIT leaves for FETCH on the cycle after step is sampled high. A step held high advances one instruction per instruction period; it does not skip instructions.
  - HALT and reset behave unchanged.
- When not defined: no step port; behaviour exactly as above.

Test Plan:
- LDI/ADD with carry: fetch 16'h840F (LDI R1,0x0F), 16'h88F1 (LDI R2,0xF1), then 16'h0600 (ADD R1,R2), imem_valid in same cycle as req → R1=0x00, flag_z=1, flag_c=alu_carry=1, pc=3. Each ALU instruction takes exactly 4 cycles.
- Logic op clears C/V: after previous, 16'h2400 (AND R1,R0) → R1=0x00, flag_z=1, flag_c=0, flag_v=0.
- Branching:
  - With flag_z=1: 16'hA010 (JZ 0x10) → pc=0x10 two cycles later, no register change.
  - With flag_z=0: same JZ → pc=prev+1.
  - 16'h90FF (JMP 0xFF), then NOP 16'hB000 → pc wraps 0xFF→0x00.
- Fetch timeout: hold imem_valid=0 with FETCH_TIMEOUT=16 → after 16 cycles of imem_req, fault=1, halted=1, imem_req=0. A later imem_valid is ignored.
- HALT and reset mid-op: 16'hF000 → halted=1, pc frozen. Separately, assert rst during EXECUTE of an ADD → next cycle state FETCH, pc=RESET_PC, R0..R3=0, flags=0, no writeback occurs.
- Wait states: insert 3 idle cycles before imem_valid on an LDI → instruction completes in 7 cycles with the correct result; imem_addr stays stable throughout FETCH.

Source files
------------

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle fetch/decode/execute/writeback sequencer for
// the 8-bit ALU. It owns the PC, a 4x8 register file, the Z/C/V flags, jumps,
// HALT and the sticky fetch-timeout fault.
// Optional build macro CPU_SINGLE_STEP_EN adds a 'step' input and a STEP_WAIT
// state that gates each new instruction fetch.
module cpu_control_unit #(
  parameter int unsigned PC_W          = 8,
  parameter int unsigned RESET_PC      = 0,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
`ifdef CPU_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [3:0]      alu_opcode,
  input  logic [7:0]      alu_result,
  input  logic            alu_carry,
  input  logic            alu_overflow,
  output logic [PC_W-1:0] pc,
  output logic            flag_z,
  output logic            flag_c,
  output logic            flag_v,
  output logic            halted,
  output logic            fault,
  input  logic [1:0]      dbg_sel,
  output logic [7:0]      dbg_data
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT,
    S_STEP_WAIT
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [PC_W-1:0] RESET_PC_V   = RESET_PC[PC_W-1:0];
  localparam logic [7:0]      TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  // Where an instruction goes once it has finished with the PC.
`ifdef CPU_SINGLE_STEP_EN
  localparam state_t RET_STATE = S_STEP_WAIT;
`else
  localparam state_t RET_STATE = S_FETCH;
`endif

  state_t          state;
  logic [15:0]     ir;
  logic [7:0]      regs [4];
  logic [7:0]      res_q;
  logic            carry_q;
  logic            ovf_q;
  logic [7:0]      tmo_cnt;

  logic [3:0]      op;
  logic [1:0]      rd;
  logic [1:0]      rs;
  logic [7:0]      imm;
  logic [PC_W-1:0] pc_inc;

  assign op     = ir[15:12];
  assign rd     = ir[11:10];
  assign rs     = ir[9:8];
  assign imm    = ir[7:0];
  assign pc_inc = pc + PC_W'(1);

  // Request is a pure function of state, but stays low while reset is held.
  assign imem_req  = (state == S_FETCH) && !rst;
  assign imem_addr = pc;
  assign dbg_data  = regs[dbg_sel];

  // Sequencer: state, PC, register file, ALU operands, flags and fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC_V;
      ir         <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_cnt    <= '0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      flag_v     <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
      // NOTE: the register file is only four flops and architecturally
      // defined as zero after reset, so it is cleared here rather than
      // being mapped to an unreset RAM.
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      // NOTE: every state update uses <= so all reads in this block see the
      // values from before the edge, regardless of statement order.
      unique case (state)
        S_FETCH: begin
          if (imem_valid) begin
            ir      <= imem_rdata;
            tmo_cnt <= '0;
            state   <= S_DECODE;
          end else if (tmo_cnt == TIMEOUT_LAST) begin
            fault  <= 1'b1;
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        S_DECODE: begin
          if (op <= OP_LDI) begin
            alu_a      <= regs[rd];
            alu_b      <= (op == OP_LDI) ? imm : regs[rs];
            alu_opcode <= op;
            state      <= S_EXECUTE;
          end else if (op == OP_JMP) begin
            pc    <= PC_W'(imm);
            state <= RET_STATE;
          end else if (op == OP_JZ) begin
            pc    <= flag_z ? PC_W'(imm) : pc_inc;
            state <= RET_STATE;
          end else if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            pc    <= pc_inc;
            state <= RET_STATE;
          end
        end

        S_EXECUTE: begin
          res_q   <= alu_result;
          carry_q <= alu_carry;
          ovf_q   <= alu_overflow;
          state   <= S_WRITEBACK;
        end

        S_WRITEBACK: begin
          regs[rd] <= res_q;
          flag_z   <= (res_q == 8'h00);
          if (op == OP_ADD || op == OP_SUB) begin
            flag_c <= carry_q;
            flag_v <= ovf_q;
          end else begin
            flag_c <= 1'b0;
            flag_v <= 1'b0;
          end
          pc    <= pc_inc;
          state <= RET_STATE;
        end

        S_STEP_WAIT: begin
`ifdef CPU_SINGLE_STEP_EN
          if (step) state <= S_FETCH;
`else
          state <= S_FETCH;
`endif
        end

        S_HALT: begin
          state <= S_HALT;
        end

        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: a program-memory responder with
// programmable wait states, a small reference ALU, a table of instruction
// vectors run back to back, and directed HALT / reset / timeout sequences.
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_result;
  logic        alu_carry;
  logic        alu_overflow;
  logic [7:0]  pc;
  logic        flag_z;
  logic        flag_c;
  logic        flag_v;
  logic        halted;
  logic        fault;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;
`ifdef CPU_SINGLE_STEP_EN
  logic        step = 1'b1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Instruction memory responder.
  logic [15:0] prog [256];
  int          wait_cycles;
  int          req_cnt;
  logic        valid_en;
  logic        force_valid;

  always #5 clk = ~clk;

  cpu_control_unit #(.PC_W(8), .RESET_PC(0), .FETCH_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef CPU_SINGLE_STEP_EN
    .step         (step),
`endif
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .pc           (pc),
    .flag_z       (flag_z),
    .flag_c       (flag_c),
    .flag_v       (flag_v),
    .halted       (halted),
    .fault        (fault),
    .dbg_sel      (dbg_sel),
    .dbg_data     (dbg_data)
  );

  assign imem_rdata = prog[imem_addr];
  assign imem_valid = force_valid |
                      (valid_en & imem_req & (req_cnt >= wait_cycles));

  // Counts fetch cycles that have gone without a response.
  always_ff @(posedge clk) begin
    if (rst || !imem_req || imem_valid) req_cnt <= 0;
    else                                req_cnt <= req_cnt + 1;
  end

  // Reference ALU: 0 ADD, 1 SUB (carry = borrow), 2 AND, 3 OR, 4 XOR,
  // 5 NOT A, 6 SHL, 7 SHR, 8 pass B.
  always_comb begin
    logic [8:0] sum;
    alu_result   = 8'h00;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    sum          = 9'h000;
    case (alu_opcode)
      4'h0: begin
        sum          = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = sum[7:0];
        alu_carry    = sum[8];
        alu_overflow = (alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]);
      end
      4'h1: begin
        alu_result   = alu_a - alu_b;
        alu_carry    = alu_a < alu_b;
        alu_overflow = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      4'h2: alu_result = alu_a & alu_b;
      4'h3: alu_result = alu_a | alu_b;
      4'h4: alu_result = alu_a ^ alu_b;
      4'h5: alu_result = ~alu_a;
      4'h6: alu_result = {alu_a[6:0], 1'b0};
      4'h7: alu_result = {1'b0, alu_a[7:1]};
      4'h8: alu_result = alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic read_reg(input logic [1:0] sel, input string name,
                          input logic [7:0] exp);
    dbg_sel = sel;
    #1;
    check(name, dbg_data, exp);
  endtask

  // Holds reset across one edge, confirms no request while it is still high.
  task automatic do_reset();
    rst = 1'b1;
    cycle();
    check("req_low_in_reset", imem_req, 1'b0);
    rst = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [15:0] instr;
    int          waits;
    int          lat;
    logic [7:0]  exp_pc;
    logic [1:0]  sel;
    logic [7:0]  exp_reg;
    logic [2:0]  exp_zcv;
  } vec_t;

  vec_t vecs [14];
  logic [7:0] cur_pc;

  initial begin
    rst         = 1'b1;
    valid_en    = 1'b1;
    force_valid = 1'b0;
    wait_cycles = 0;
    dbg_sel     = 2'd0;
    for (int i = 0; i < 256; i++) prog[i] = 16'hB000;

    //            instr     wait lat pc     reg   value  zcv
    vecs[0]  = '{16'h840F,  0,  4, 8'h01, 2'd1, 8'h0F, 3'b000}; // LDI R1,0F
    vecs[1]  = '{16'h88F1,  0,  4, 8'h02, 2'd2, 8'hF1, 3'b000}; // LDI R2,F1
    vecs[2]  = '{16'h0600,  0,  4, 8'h03, 2'd1, 8'h00, 3'b110}; // ADD R1,R2
    vecs[3]  = '{16'h2400,  0,  4, 8'h04, 2'd1, 8'h00, 3'b100}; // AND R1,R0
    vecs[4]  = '{16'hA010,  0,  2, 8'h10, 2'd1, 8'h00, 3'b100}; // JZ taken
    vecs[5]  = '{16'h8C80,  0,  4, 8'h11, 2'd3, 8'h80, 3'b000}; // LDI R3,80
    vecs[6]  = '{16'hA010,  0,  2, 8'h12, 2'd3, 8'h80, 3'b000}; // JZ not taken
    vecs[7]  = '{16'h0F00,  2,  6, 8'h13, 2'd3, 8'h00, 3'b111}; // ADD R3,R3
    vecs[8]  = '{16'h1600,  0,  4, 8'h14, 2'd1, 8'h0F, 3'b010}; // SUB R1,R2
    vecs[9]  = '{16'hB000,  0,  2, 8'h15, 2'd1, 8'h0F, 3'b010}; // NOP
    vecs[10] = '{16'h90FF,  0,  2, 8'hFF, 2'd1, 8'h0F, 3'b010}; // JMP FF
    vecs[11] = '{16'hB000,  0,  2, 8'h00, 2'd1, 8'h0F, 3'b010}; // NOP, wrap
    vecs[12] = '{16'h8455,  3,  7, 8'h01, 2'd1, 8'h55, 3'b000}; // LDI, 3 waits
    vecs[13] = '{16'h8833, 15, 19, 8'h02, 2'd2, 8'h33, 3'b000}; // valid on last cycle

    // Reset state.
    do_reset();
    check("rst_pc", pc, 8'h00);
    check("rst_req", imem_req, 1'b1);
    check("rst_flags", {flag_z, flag_c, flag_v}, 3'b000);
    check("rst_status", {halted, fault}, 2'b00);
    check("rst_alu", {alu_a, alu_b, alu_opcode}, 20'h0);
    for (int r = 0; r < 4; r++) read_reg(2'(r), "rst_reg", 8'h00);

    // Table-driven instruction stream.
    cur_pc = 8'h00;
    for (int v = 0; v < 14; v++) begin
      prog[cur_pc] = vecs[v].instr;
      wait_cycles  = vecs[v].waits;
      #1;
      for (int c = 0; c < vecs[v].lat; c++) begin
        check($sformatf("v%0d_req_c%0d", v, c), imem_req, (c <= vecs[v].waits));
        if (c <= vecs[v].waits)
          check($sformatf("v%0d_addr_c%0d", v, c), imem_addr, cur_pc);
        cycle();
      end
      check($sformatf("v%0d_done_req", v), imem_req, 1'b1);
      check($sformatf("v%0d_pc", v), pc, vecs[v].exp_pc);
      check($sformatf("v%0d_zcv", v), {flag_z, flag_c, flag_v}, vecs[v].exp_zcv);
      read_reg(vecs[v].sel, $sformatf("v%0d_reg", v), vecs[v].exp_reg);
      cur_pc = vecs[v].exp_pc;
    end

    // HALT: absorbing, state frozen, stray valid ignored, debug port live.
    prog[2]     = 16'hF000;
    wait_cycles = 0;
    cycles(2);
    check("halt_halted", halted, 1'b1);
    check("halt_req", imem_req, 1'b0);
    check("halt_pc", pc, 8'h02);
    force_valid = 1'b1;
    cycles(5);
    force_valid = 1'b0;
    check("halt_still", {halted, fault, imem_req}, 3'b100);
    check("halt_pc_frozen", pc, 8'h02);
    read_reg(2'd1, "halt_dbg_r1", 8'h55);

    // Reset leaves HALT and clears everything.
    do_reset();
    check("rst2_pc", pc, 8'h00);
    check("rst2_halted", halted, 1'b0);
    read_reg(2'd1, "rst2_r1", 8'h00);
    read_reg(2'd2, "rst2_r2", 8'h00);

    // Reset during EXECUTE of an ADD suppresses its writeback.
    prog[0] = 16'h84C0;            // LDI R1,C0
    prog[1] = 16'h0500;            // ADD R1,R1 -> 80, C=1
    prog[2] = 16'h0500;            // ADD R1,R1, interrupted
    cycles(8);
    read_reg(2'd1, "mid_pre_r1", 8'h80);
    check("mid_pre_zcv", {flag_z, flag_c, flag_v}, 3'b010);
    cycles(2);
    check("mid_in_exec", {alu_a, alu_opcode}, {8'h80, 4'h0});
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("mid_pc", pc, 8'h00);
    check("mid_zcv", {flag_z, flag_c, flag_v}, 3'b000);
    check("mid_req", imem_req, 1'b1);
    read_reg(2'd1, "mid_r1", 8'h00);
    cycles(2);
    read_reg(2'd1, "mid_no_wb_r1", 8'h00);

    // Fetch timeout: 16 request cycles without valid, then fault + HALT.
    valid_en = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("tmo_req_%0d", i), imem_req, 1'b1);
      if (i == 15) check("tmo_no_fault_yet", fault, 1'b0);
      cycle();
    end
    check("tmo_fault", {fault, halted, imem_req}, 3'b110);
    force_valid = 1'b1;
    cycles(3);
    force_valid = 1'b0;
    check("tmo_valid_ignored", {fault, halted, imem_req}, 3'b110);
    check("tmo_pc", pc, 8'h00);
    valid_en = 1'b1;
    do_reset();
    check("tmo_rst_clears", {fault, halted}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
